// File: rtl/nios_mul_pkg.sv
// Shared op encoding and decode for the Nios pipelined multiplier.
package nios_mul_pkg;

  typedef enum logic [1:0] {
    MUL_LO = 2'b00,
    MUL_SS = 2'b01,
    MUL_SU = 2'b10,
    MUL_UU = 2'b11
  } mul_op_e;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
    logic sel_hi;
  } op_dec_t;

  function automatic op_dec_t decode_op(input mul_op_e op);
    op_dec_t d;
    d.sel_hi   = (op != MUL_LO);
    d.a_signed = (op == MUL_SS) || (op == MUL_SU);
    d.b_signed = (op == MUL_SS);
    return d;
  endfunction

endpackage

// File: rtl/nios_mul_pp.sv
// HALF_W x HALF_W unsigned partial-product multiplier, optionally registered.
// Kept as its own module so each instance lands on one DSP block.
module nios_mul_pp #(
  parameter int HALF_W = 16,
  parameter bit REG    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [HALF_W-1:0]     a,
  input  logic [HALF_W-1:0]     b,
  output logic [2*HALF_W-1:0]   p
);

  logic [2*HALF_W-1:0] p_d;

  always_comb begin
    p_d = {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};
  end

  generate
    if (REG) begin : g_reg
      logic [2*HALF_W-1:0] p_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          p_q <= '0;
        end else if (en) begin
          p_q <= p_d;
        end
      end
      assign p = p_q;
    end else begin : g_comb
      assign p = p_d;
    end
  endgenerate

endmodule

// File: rtl/nios_mul_pipe.sv
// Pipelined DATA_W x DATA_W multiplier with signed/unsigned high/low select,
// valid/ready flow control, flush and a pass-through tag.
module nios_mul_pipe
  import nios_mul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter bit PP_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PW     = 2 * DATA_W;

  logic en;
  logic accept;

  logic              out_valid_q,  out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [TAG_W-1:0]  out_tag_q,    out_tag_d;

  // Every stage advances together; a stalled output freezes the whole pipe.
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en & ~flush;
  assign accept   = in_valid & in_ready;

  op_dec_t           in_dec;
  logic [DATA_W-1:0] in_corr;

  // Signed operands are treated as unsigned, then the high half is fixed up.
  always_comb begin
    in_dec  = decode_op(mul_op_e'(in_op));
    in_corr = '0;
    if (in_dec.a_signed && in_a[DATA_W-1]) in_corr = in_corr + in_b;
    if (in_dec.b_signed && in_b[DATA_W-1]) in_corr = in_corr + in_a;
  end

  logic [DATA_W-1:0] pp [4];

  // Instance gi multiplies half (gi/2) of a by half (gi%2) of b.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pp
      nios_mul_pp #(.HALF_W(HALF_W), .REG(PP_REG)) u_pp (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .a       (in_a[(gi/2)*HALF_W +: HALF_W]),
        .b       (in_b[(gi%2)*HALF_W +: HALF_W]),
        .p       (pp[gi])
      );
    end
  endgenerate

  logic              st_valid;
  logic              st_sel_hi;
  logic [TAG_W-1:0]  st_tag;
  logic [DATA_W-1:0] st_corr;

  generate
    if (PP_REG) begin : g_s1
      logic              s1_valid_q,  s1_valid_d;
      logic              s1_sel_hi_q, s1_sel_hi_d;
      logic [TAG_W-1:0]  s1_tag_q,    s1_tag_d;
      logic [DATA_W-1:0] s1_corr_q,   s1_corr_d;

      always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sel_hi_d = s1_sel_hi_q;
        s1_tag_d    = s1_tag_q;
        s1_corr_d   = s1_corr_q;
        if (en) begin
          s1_valid_d  = in_valid;
          s1_sel_hi_d = in_dec.sel_hi;
          s1_tag_d    = in_tag;
          s1_corr_d   = in_corr;
        end
        if (flush) s1_valid_d = 1'b0;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_valid_q  <= 1'b0;
          s1_sel_hi_q <= 1'b0;
          s1_tag_q    <= '0;
          s1_corr_q   <= '0;
        end else begin
          s1_valid_q  <= s1_valid_d;
          s1_sel_hi_q <= s1_sel_hi_d;
          s1_tag_q    <= s1_tag_d;
          s1_corr_q   <= s1_corr_d;
        end
      end

      assign st_valid  = s1_valid_q;
      assign st_sel_hi = s1_sel_hi_q;
      assign st_tag    = s1_tag_q;
      assign st_corr   = s1_corr_q;
    end else begin : g_s0
      assign st_valid  = accept;
      assign st_sel_hi = in_dec.sel_hi;
      assign st_tag    = in_tag;
      assign st_corr   = in_corr;
    end
  endgenerate

  logic [PW-1:0]     prod;
  logic [DATA_W-1:0] result;

  always_comb begin
    prod = {{DATA_W{1'b0}}, pp[0]}
         + ({{DATA_W{1'b0}}, pp[1]} << HALF_W)
         + ({{DATA_W{1'b0}}, pp[2]} << HALF_W)
         + {pp[3], {DATA_W{1'b0}}}
         - {st_corr, {DATA_W{1'b0}}};
    result = st_sel_hi ? prod[PW-1:DATA_W] : prod[DATA_W-1:0];
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    if (en) begin
      out_valid_d  = st_valid;
      out_result_d = result;
      out_tag_d    = st_tag;
    end
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_nios_mul_pipe.sv
// Directed bench for nios_mul_pipe (default parameters, latency 2).
module tb_nios_mul_pipe;
  import nios_mul_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b, out_result, exp_res;
  logic [4:0]  in_tag, out_tag;

  int n_cmp = 0;
  int n_bad = 0;
  logic [36:0] sb [$];
  logic [36:0] sb_head;

  always #5 clk = ~clk;

  nios_mul_pipe #(.DATA_W(32), .TAG_W(5), .PP_REG(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        sb_head = sb.pop_front();
        $display("out tag=%0d result=%08h expected tag=%0d result=%08h",
                 out_tag, out_result, sb_head[36:32], sb_head[31:0]);
        check("out_result", out_result, sb_head[31:0]);
        check("out_tag", out_tag, sb_head[36:32]);
      end
    end
    if (reset_n && in_valid && in_ready) sb.push_back({in_tag, exp_res});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; exp_res = exp;
  endtask

  task automatic single(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    drive(op, a, b, tag, exp);
    #1 check({name, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    check({name, "_valid_c1"}, out_valid, 0);
    tick();
    check({name, "_valid_c2"}, out_valid, 1);
    check({name, "_result"}, out_result, exp);
    check({name, "_tag"}, out_tag, tag);
    tick();
    check({name, "_valid_c3"}, out_valid, 0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp;
  } vec_t;

  vec_t b2b [8];

  initial begin
    b2b[0] = '{MUL_LO, 32'h00000003, 32'h00000005, 32'h0000000F};
    b2b[1] = '{MUL_LO, 32'h12345678, 32'h00000010, 32'h23456780};
    b2b[2] = '{MUL_UU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    b2b[3] = '{MUL_SS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    b2b[4] = '{MUL_SU, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    b2b[5] = '{MUL_SS, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    b2b[6] = '{MUL_UU, 32'h00020000, 32'h00008000, 32'h00000001};
    b2b[7] = '{MUL_LO, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};

    reset_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0; exp_res = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    reset_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;

    single("mul_lo", MUL_LO, 32'h0000FFFF, 32'h00010001, 5'd1, 32'hFFFFFFFF);
    single("mulxss", MUL_SS, 32'hFFFFFFFF, 32'h00000002, 5'd2, 32'hFFFFFFFF);
    single("mulxuu", MUL_UU, 32'hFFFFFFFF, 32'h00000002, 5'd3, 32'h00000001);
    single("mulxsu", MUL_SU, 32'h80000000, 32'hFFFFFFFF, 5'd4, 32'h80000000);

    for (int i = 0; i < 11; i++) begin
      if (i < 8) drive(b2b[i].op, b2b[i].a, b2b[i].b, 5'(i), b2b[i].exp);
      else in_valid = 1'b0;
      #1 check($sformatf("b2b_valid_c%0d", i), out_valid, 64'(i >= 2 && i < 10));
      tick();
    end

    // Stall: A reaches the output, then out_ready drops with C waiting.
    drive(MUL_UU, 32'hFFFFFFFF, 32'h80000000, 5'd10, 32'h7FFFFFFF);
    tick();
    drive(MUL_LO, 32'h00000007, 32'h00000006, 5'd11, 32'h0000002A);
    tick();
    out_ready = 1'b0;
    drive(MUL_SS, 32'h80000000, 32'h80000000, 5'd12, 32'h40000000);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("stall_in_ready_%0d", k), in_ready, 0);
      check($sformatf("stall_valid_%0d", k), out_valid, 1);
      check($sformatf("stall_tag_%0d", k), out_tag, 10);
      check($sformatf("stall_result_%0d", k), out_result, 32'h7FFFFFFF);
      tick();
    end
    out_ready = 1'b1;
    #1 check("stall_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("stall_drained", sb.size(), 0);

    // Flush with two ops in flight and a third offered in the flush cycle.
    drive(MUL_LO, 32'h00000009, 32'h00000009, 5'd20, 32'h00000051);
    tick();
    drive(MUL_LO, 32'h0000000A, 32'h0000000A, 5'd21, 32'h00000064);
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    drive(MUL_LO, 32'h0000000B, 32'h0000000B, 5'd22, 32'h00000079);
    #1 check("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("flush_no_valid_%0d", k), out_valid, 0);
      tick();
    end
    single("post_flush", MUL_SS, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd23, 32'h3FFFFFFF);

    // Asynchronous reset mid-cycle with two ops in flight.
    drive(MUL_LO, 32'h00000002, 32'h00000003, 5'd25, 32'h00000006);
    tick();
    drive(MUL_LO, 32'h00000004, 32'h00000005, 5'd26, 32'h00000014);
    tick();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_result", out_result, 0);
    check("arst_out_tag", out_tag, 0);
    sb.delete();
    #10 reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("arst_no_valid_%0d", k), out_valid, 0);
    end
    single("post_reset", MUL_UU, 32'h00010000, 32'h00010000, 5'd27, 32'h00000001);

    repeat (2) tick();
    check("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
